pipelined_control_unit: RTL and testbench
=========================================

# pipelined_control_unit

Pipelined successor to the single-cycle control decoder of the LEGv8 CPU. Decodes the ID-stage instruction into a control word and carries it through registered EX, MEM and WB stages. Owns the NZCV flag register and resolves B, B.cond (ID) and CBZ (EX). Parameters select full B.cond condition support and flag forwarding versus stall.

## Interface
- COND_FULL, 1: 1 = B.cond supports EQ/NE/GE/LT/GT/LE; 0 = LT only, other conditions illegal
- FLAG_FWD, 1: 1 = forward live ALU flags to ID B.cond; 0 = stall one cycle instead
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  ID instruction present
- instruction  in  32  ID-stage instruction
- stall_in  in  1  freeze all stage registers and flags
- alu_zero, alu_negative, alu_carry, alu_overflow  in  1 each  EX-stage ALU flags
- reg2loc, uncond_br, br_taken_id  out  1 each  ID decode/branch outputs
- hazard_stall  out  1  hold fetch/ID this cycle
- illegal  out  1  ID instruction valid but unrecognised
- ex_alu_src, ex_set_flags, ex_br_taken  out  1 each  EX controls; ex_br_taken = CBZ taken
- ex_alu_op  out  3  000 pass B, 010 add, 011 sub, 100 and, 110 xor, 111 lsr
- ex_imm_sel  out  2  00 none, 01 imm12, 10 dt9, 11 shamt
- mem_write, mem_to_reg  out  1 each  MEM controls
- wb_reg_write, wb_mem_to_reg  out  1 each  WB controls
- flags_q  out  4  NZCV register

## Operation
- Decode on instruction[31:21]: LDUR 11111000010, STUR 11111000000, ADDI 1001000100x, ADDS 10101011000, SUBS 11101011000, AND 10001010000, EOR 11001010000, LSR 11010011010, B 000101xxxxx, CBZ 10110100xxx, B.cond 01010100xxx (cond = instruction[3:0]).
- Control words (unlisted = 0): LDUR alu_src, imm dt9, add, mem_to_reg, reg_write. STUR alu_src, dt9, add, mem_write. ADDI alu_src, imm12, add, reg_write. ADDS reg2loc, add, set_flags, reg_write. SUBS reg2loc, sub, set_flags, reg_write. AND reg2loc, and, reg_write. EOR reg2loc, xor, reg_write. LSR alu_src, shamt, lsr, reg_write. CBZ pass B, cbz. B uncond_br. B.cond branch only.
- No X outputs ever. Unrecognised opcode or disallowed cond: illegal=1, all-zero control word (NOP).
- B: br_taken_id=1, uncond_br=1. B.cond: br_taken_id = cond(F), F = flags_q, or live {N,Z,C,V} ALU flags when FLAG_FWD=1 and EX holds a valid set_flags op. EQ Z; NE !Z; GE N==V; LT N!=V; GT !Z&&N==V; LE Z||N!=V.
- CBZ: ex_br_taken = alu_zero while CBZ valid in EX.
- Flags: on edge with EX valid, ex_set_flags=1, stall_in=0, flags_q <= {N,Z,C,V} from ALU.
- Hazard (FLAG_FWD=0): ID B.cond valid while EX holds valid flag setter -> hazard_stall=1, br_taken_id=0, bubble into EX, ID held.
- ex_br_taken=1: ID instruction squashed (bubble into EX), br_taken_id forced 0 and illegal forced 0.
- stall_in=1: all stage registers and flags_q hold; br_taken_id, ex_br_taken, hazard_stall forced 0; stage outputs hold.

## Timing
- Reset (async, reset_n=0): all stage valids 0, flags_q=0000, every registered output 0; combinational ID outputs follow instruction with instr_valid.
- ID outputs combinational; EX/MEM/WB controls appear 1/2/3 edges after ID acceptance, absent stalls.
- Bubble: all controls 0, valid 0. Flag update visible on flags_q one edge after EX.
- Reset asserted mid-pipeline discards all in-flight instructions; no flag or write control survives.

## Test plan
- Reset: reset_n=0 mid-stream with ADDS in EX -> flags_q=0000, all stage controls 0 immediately and after release.
- Pipeline: LDUR,STUR,ADDI,EOR,LSR back-to-back -> wb_reg_write 1,0,1,1,1 and wb_mem_to_reg 1,0,0,0,0 on edges 3..7; mem_write high only edge 3 (STUR).
- Flags: SUBS with ALU N=1,Z=0,C=0,V=0 then B.LT -> FLAG_FWD=1: br_taken_id=1 same cycle, hazard_stall=0; FLAG_FWD=0: hazard_stall=1 one cycle, then br_taken_id=1, flags_q=1000.
- Conditions: flags_q=0100, cond EQ/NE/GT/LE -> 1/0/0/1; COND_FULL=0, cond EQ -> illegal=1, br_taken_id=0.
- CBZ in EX alu_zero=1 with B.cond (true) in ID -> ex_br_taken=1, br_taken_id=0, next EX is bubble.
- stall_in=1 for 3 cycles with ADDS in EX -> flags_q unchanged, controls frozen, branch outputs 0; resume -> flags update one edge later.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// LEGv8 control: combinational ID decode/branch resolve, registered EX/MEM/WB control words and NZCV flags.
// EX/MEM/WB controls lag ID acceptance by 1/2/3 edges; stall_in freezes every stage, hazard_stall/ex_br_taken inject bubbles.
module pipelined_control_unit #(
    parameter bit COND_FULL = 1'b1,
    parameter bit FLAG_FWD  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    input  logic [31:0] instruction,
    input  logic        stall_in,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    output logic        reg2loc,
    output logic        uncond_br,
    output logic        br_taken_id,
    output logic        hazard_stall,
    output logic        illegal,
    output logic        ex_alu_src,
    output logic        ex_set_flags,
    output logic        ex_br_taken,
    output logic [2:0]  ex_alu_op,
    output logic [1:0]  ex_imm_sel,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [3:0]  flags_q
);

    localparam logic [2:0] OP_PASSB = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_LSR   = 3'b111;

    localparam logic [1:0] IMM_12    = 2'b01;
    localparam logic [1:0] IMM_DT9   = 2'b10;
    localparam logic [1:0] IMM_SHAMT = 2'b11;

    localparam logic [3:0] C_EQ = 4'h0;
    localparam logic [3:0] C_NE = 4'h1;
    localparam logic [3:0] C_GE = 4'hA;
    localparam logic [3:0] C_LT = 4'hB;
    localparam logic [3:0] C_GT = 4'hC;
    localparam logic [3:0] C_LE = 4'hD;

    // An all-zero word is a bubble: it writes nothing and sets no flags.
    typedef struct packed {
        logic       alu_src;
        logic [1:0] imm_sel;
        logic [2:0] alu_op;
        logic       set_flags;
        logic       cbz;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    typedef struct packed {
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    ctrl_t      id_ctrl;
    ctrl_t      ex_q;
    mem_ctrl_t  mem_q;
    wb_ctrl_t   wb_q;

    logic       id_r2l;
    logic       id_ub;
    logic       id_bcond;
    logic       id_known;
    logic       cond_legal;
    logic       cond_true;
    logic [3:0] cond;
    logic       fwd;
    logic       cond_n;
    logic       cond_z;
    logic       cond_v;
    logic       accept;
    logic [3:0] alu_nzcv;
    logic       unused_bits;

    assign cond        = instruction[3:0];
    assign alu_nzcv    = {alu_negative, alu_zero, alu_carry, alu_overflow};
    assign unused_bits = ^instruction[20:4];

    always_comb begin
        cond_legal = (cond == C_LT);
        if (COND_FULL) begin
            cond_legal = cond inside {C_EQ, C_NE, C_GE, C_LT, C_GT, C_LE};
        end
    end

    always_comb begin
        id_ctrl  = '0;
        id_r2l   = 1'b0;
        id_ub    = 1'b0;
        id_bcond = 1'b0;
        id_known = 1'b1;
        casez (instruction[31:21])
            11'b11111000010: begin
                id_ctrl.alu_src    = 1'b1;
                id_ctrl.imm_sel    = IMM_DT9;
                id_ctrl.alu_op     = OP_ADD;
                id_ctrl.mem_to_reg = 1'b1;
                id_ctrl.reg_write  = 1'b1;
            end
            11'b11111000000: begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.imm_sel   = IMM_DT9;
                id_ctrl.alu_op    = OP_ADD;
                id_ctrl.mem_write = 1'b1;
            end
            11'b1001000100?: begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.imm_sel   = IMM_12;
                id_ctrl.alu_op    = OP_ADD;
                id_ctrl.reg_write = 1'b1;
            end
            11'b10101011000: begin
                id_r2l            = 1'b1;
                id_ctrl.alu_op    = OP_ADD;
                id_ctrl.set_flags = 1'b1;
                id_ctrl.reg_write = 1'b1;
            end
            11'b11101011000: begin
                id_r2l            = 1'b1;
                id_ctrl.alu_op    = OP_SUB;
                id_ctrl.set_flags = 1'b1;
                id_ctrl.reg_write = 1'b1;
            end
            11'b10001010000: begin
                id_r2l            = 1'b1;
                id_ctrl.alu_op    = OP_AND;
                id_ctrl.reg_write = 1'b1;
            end
            11'b11001010000: begin
                id_r2l            = 1'b1;
                id_ctrl.alu_op    = OP_XOR;
                id_ctrl.reg_write = 1'b1;
            end
            11'b11010011010: begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.imm_sel   = IMM_SHAMT;
                id_ctrl.alu_op    = OP_LSR;
                id_ctrl.reg_write = 1'b1;
            end
            11'b000101?????: id_ub = 1'b1;
            11'b10110100???: begin
                id_ctrl.alu_op = OP_PASSB;
                id_ctrl.cbz    = 1'b1;
            end
            11'b01010100???: id_bcond = 1'b1;
            default:         id_known = 1'b0;
        endcase
        if (id_bcond && !cond_legal) begin
            id_known = 1'b0;
        end
        // Illegal or absent instructions decode to a NOP word.
        if (!id_known || !instr_valid) begin
            id_ctrl  = '0;
            id_r2l   = 1'b0;
            id_ub    = 1'b0;
            id_bcond = 1'b0;
        end
    end

    // A flag setter sitting in EX supplies the live ALU flags when forwarding is enabled.
    assign fwd    = FLAG_FWD && ex_q.set_flags;
    assign cond_n = fwd ? alu_negative : flags_q[3];
    assign cond_z = fwd ? alu_zero     : flags_q[2];
    assign cond_v = fwd ? alu_overflow : flags_q[0];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            C_EQ:    cond_true = cond_z;
            C_NE:    cond_true = !cond_z;
            C_GE:    cond_true = (cond_n == cond_v);
            C_LT:    cond_true = (cond_n != cond_v);
            C_GT:    cond_true = !cond_z && (cond_n == cond_v);
            C_LE:    cond_true = cond_z || (cond_n != cond_v);
            default: cond_true = 1'b0;
        endcase
    end

    assign ex_br_taken  = ex_q.cbz && alu_zero && !stall_in;
    assign hazard_stall = !FLAG_FWD && id_bcond && ex_q.set_flags && !stall_in;
    assign br_taken_id  = !stall_in && !ex_br_taken && !hazard_stall &&
                          (id_ub || (id_bcond && cond_true));
    assign illegal      = instr_valid && !id_known && !ex_br_taken;
    assign reg2loc      = id_r2l;
    assign uncond_br    = id_ub;
    assign accept       = instr_valid && !hazard_stall && !ex_br_taken;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            flags_q <= '0;
        end else if (!stall_in) begin
            ex_q  <= accept ? id_ctrl : '0;
            mem_q <= {ex_q.mem_write, ex_q.mem_to_reg, ex_q.reg_write};
            wb_q  <= {mem_q.mem_to_reg, mem_q.reg_write};
            if (ex_q.set_flags) begin
                flags_q <= alu_nzcv;
            end
        end
    end

    assign ex_alu_src    = ex_q.alu_src;
    assign ex_set_flags  = ex_q.set_flags;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_imm_sel    = ex_q.imm_sel;
    assign mem_write     = mem_q.mem_write;
    assign mem_to_reg    = mem_q.mem_to_reg;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_mem_to_reg = wb_q.mem_to_reg;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Drives a full-featured and a minimal (LT-only, stall-on-flags) instance with the same stimulus
// and compares both against an opcode-table pipeline model.
module tb_pipelined_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        stall_in;
    logic        alu_zero, alu_negative, alu_carry, alu_overflow;

    logic [1:0] reg2loc, uncond_br, br_taken_id, hazard_stall, illegal;
    logic [1:0] ex_alu_src, ex_set_flags, ex_br_taken;
    logic [1:0] mem_write, mem_to_reg, wb_reg_write, wb_mem_to_reg;
    logic [2:0] ex_alu_op [2];
    logic [1:0] ex_imm_sel [2];
    logic [3:0] flags_q [2];

    pipelined_control_unit #(.COND_FULL(1'b1), .FLAG_FWD(1'b1)) u_full (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instruction(instruction),
        .stall_in(stall_in), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .reg2loc(reg2loc[0]), .uncond_br(uncond_br[0]), .br_taken_id(br_taken_id[0]),
        .hazard_stall(hazard_stall[0]), .illegal(illegal[0]),
        .ex_alu_src(ex_alu_src[0]), .ex_set_flags(ex_set_flags[0]), .ex_br_taken(ex_br_taken[0]),
        .ex_alu_op(ex_alu_op[0]), .ex_imm_sel(ex_imm_sel[0]),
        .mem_write(mem_write[0]), .mem_to_reg(mem_to_reg[0]),
        .wb_reg_write(wb_reg_write[0]), .wb_mem_to_reg(wb_mem_to_reg[0]), .flags_q(flags_q[0])
    );

    pipelined_control_unit #(.COND_FULL(1'b0), .FLAG_FWD(1'b0)) u_min (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instruction(instruction),
        .stall_in(stall_in), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .reg2loc(reg2loc[1]), .uncond_br(uncond_br[1]), .br_taken_id(br_taken_id[1]),
        .hazard_stall(hazard_stall[1]), .illegal(illegal[1]),
        .ex_alu_src(ex_alu_src[1]), .ex_set_flags(ex_set_flags[1]), .ex_br_taken(ex_br_taken[1]),
        .ex_alu_op(ex_alu_op[1]), .ex_imm_sel(ex_imm_sel[1]),
        .mem_write(mem_write[1]), .mem_to_reg(mem_to_reg[1]),
        .wb_reg_write(wb_reg_write[1]), .wb_mem_to_reg(wb_mem_to_reg[1]), .flags_q(flags_q[1])
    );

    typedef struct packed {
        logic       r2l;
        logic       ub;
        logic       bcond;
        logic       cbz;
        logic       src;
        logic [1:0] imm;
        logic [2:0] op;
        logic       sf;
        logic       mw;
        logic       m2r;
        logic       rw;
    } cw_t;

    typedef struct packed {
        logic vld;
        cw_t  w;
    } slot_t;

    logic [10:0] pat[$];
    logic [10:0] msk[$];
    cw_t         word[$];

    bit          cf [2] = '{1'b1, 1'b0};
    bit          ff [2] = '{1'b1, 1'b0};
    slot_t       ex_m [2], mem_m [2], wb_m [2];
    logic [3:0]  fl_m [2];
    logic [3:0]  conds [6] = '{4'h0, 4'h1, 4'hA, 4'hB, 4'hC, 4'hD};

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic add_row(input logic [10:0] p, input logic [10:0] m, input cw_t w);
        pat.push_back(p);
        msk.push_back(m);
        word.push_back(w);
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input bit full);
        if (!full) return c == 4'hB;
        return c == 4'h0 || c == 4'h1 || (c >= 4'hA && c <= 4'hD);
    endfunction

    function automatic bit cond_eval(input logic [3:0] c, input logic [3:0] f);
        int n, z, v;
        n = f[3]; z = f[2]; v = f[0];
        case (c)
            4'h0:    return z == 1;
            4'h1:    return z == 0;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return z == 0 && n == v;
            4'hD:    return z == 1 || n != v;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void decode(input logic [31:0] ins, input bit full, output bit known, output cw_t w);
        known = 1'b0;
        w = '0;
        foreach (pat[i]) begin
            if ((ins[31:21] & msk[i]) == pat[i]) begin
                known = 1'b1;
                w = word[i];
            end
        end
        if (known && w.bcond && !cond_ok(ins[3:0], full)) begin
            known = 1'b0;
            w = '0;
        end
    endfunction

    // t: 0 LDUR 1 STUR 2 ADDI 3 ADDS 4 SUBS 5 AND 6 EOR 7 LSR 8 B 9 CBZ 10 B.cond, else random word
    function automatic logic [31:0] mk(input int t, input logic [3:0] c);
        logic [31:0] r;
        r = $urandom;
        case (t)
            0:  r[31:21] = 11'b11111000010;
            1:  r[31:21] = 11'b11111000000;
            2:  r[31:22] = 10'b1001000100;
            3:  r[31:21] = 11'b10101011000;
            4:  r[31:21] = 11'b11101011000;
            5:  r[31:21] = 11'b10001010000;
            6:  r[31:21] = 11'b11001010000;
            7:  r[31:21] = 11'b11010011010;
            8:  r[31:26] = 6'b000101;
            9:  r[31:24] = 8'b10110100;
            10: begin r[31:24] = 8'b01010100; r[3:0] = c; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic step(input bit rst, input bit vld, input logic [31:0] ins,
                        input bit stl, input logic [3:0] nzcv);
        cw_t        d, exw, memw, wbw;
        bit         known, exf, exbr, hz, br, ill;
        logic [3:0] f;
        slot_t      nex [2], nmem [2], nwb [2];
        logic [3:0] nfl [2];
        string      s;
        @(negedge clk);
        reset_n = rst;
        instr_valid = vld;
        instruction = ins;
        stall_in = stl;
        {alu_negative, alu_zero, alu_carry, alu_overflow} = nzcv;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                ex_m[k] = '0; mem_m[k] = '0; wb_m[k] = '0; fl_m[k] = '0;
            end
            s = (k == 0) ? "full" : "min";
            decode(ins, cf[k], known, d);
            if (!vld) d = '0;
            exw  = ex_m[k].vld  ? ex_m[k].w  : '0;
            memw = mem_m[k].vld ? mem_m[k].w : '0;
            wbw  = wb_m[k].vld  ? wb_m[k].w  : '0;
            exf  = exw.sf;
            exbr = !stl && exw.cbz && nzcv[2];
            f    = (ff[k] && exf) ? nzcv : fl_m[k];
            hz   = !ff[k] && !stl && d.bcond && exf;
            br   = !stl && !exbr && !hz && (d.ub || (d.bcond && cond_eval(ins[3:0], f)));
            ill  = vld && !known && !exbr;

            check_eq({"reg2loc.", s},      32'(reg2loc[k]),      32'(d.r2l));
            check_eq({"uncond_br.", s},    32'(uncond_br[k]),    32'(d.ub));
            check_eq({"br_taken_id.", s},  32'(br_taken_id[k]),  32'(br));
            check_eq({"hazard_stall.", s}, 32'(hazard_stall[k]), 32'(hz));
            check_eq({"illegal.", s},      32'(illegal[k]),      32'(ill));
            check_eq({"ex_br_taken.", s},  32'(ex_br_taken[k]),  32'(exbr));
            check_eq({"ex_alu_src.", s},   32'(ex_alu_src[k]),   32'(exw.src));
            check_eq({"ex_set_flags.", s}, 32'(ex_set_flags[k]), 32'(exw.sf));
            check_eq({"ex_alu_op.", s},    32'(ex_alu_op[k]),    32'(exw.op));
            check_eq({"ex_imm_sel.", s},   32'(ex_imm_sel[k]),   32'(exw.imm));
            check_eq({"mem_write.", s},    32'(mem_write[k]),    32'(memw.mw));
            check_eq({"mem_to_reg.", s},   32'(mem_to_reg[k]),   32'(memw.m2r));
            check_eq({"wb_reg_write.", s}, 32'(wb_reg_write[k]), 32'(wbw.rw));
            check_eq({"wb_mem_to_reg.", s},32'(wb_mem_to_reg[k]),32'(wbw.m2r));
            check_eq({"flags_q.", s},      32'(flags_q[k]),      32'(fl_m[k]));

            nex[k] = ex_m[k]; nmem[k] = mem_m[k]; nwb[k] = wb_m[k]; nfl[k] = fl_m[k];
            if (!rst) begin
                nex[k] = '0; nmem[k] = '0; nwb[k] = '0; nfl[k] = '0;
            end else if (!stl) begin
                if (exf) nfl[k] = nzcv;
                nwb[k]  = mem_m[k];
                nmem[k] = ex_m[k];
                nex[k]  = (vld && !hz && !exbr) ? slot_t'{vld: 1'b1, w: d} : '0;
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            ex_m[k] = nex[k]; mem_m[k] = nmem[k]; wb_m[k] = nwb[k]; fl_m[k] = nfl[k];
        end
    endtask

    initial begin
        reset_n = 1'b0;
        instr_valid = 1'b0;
        instruction = '0;
        stall_in = 1'b0;
        {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            ex_m[k] = '0; mem_m[k] = '0; wb_m[k] = '0; fl_m[k] = '0;
        end

        add_row(11'b11111000010, 11'h7FF, cw_t'{src: 1'b1, imm: 2'b10, op: 3'b010, m2r: 1'b1, rw: 1'b1, default: '0});
        add_row(11'b11111000000, 11'h7FF, cw_t'{src: 1'b1, imm: 2'b10, op: 3'b010, mw: 1'b1, default: '0});
        add_row(11'b10010001000, 11'h7FE, cw_t'{src: 1'b1, imm: 2'b01, op: 3'b010, rw: 1'b1, default: '0});
        add_row(11'b10101011000, 11'h7FF, cw_t'{r2l: 1'b1, op: 3'b010, sf: 1'b1, rw: 1'b1, default: '0});
        add_row(11'b11101011000, 11'h7FF, cw_t'{r2l: 1'b1, op: 3'b011, sf: 1'b1, rw: 1'b1, default: '0});
        add_row(11'b10001010000, 11'h7FF, cw_t'{r2l: 1'b1, op: 3'b100, rw: 1'b1, default: '0});
        add_row(11'b11001010000, 11'h7FF, cw_t'{r2l: 1'b1, op: 3'b110, rw: 1'b1, default: '0});
        add_row(11'b11010011010, 11'h7FF, cw_t'{src: 1'b1, imm: 2'b11, op: 3'b111, rw: 1'b1, default: '0});
        add_row(11'b00010100000, 11'h7E0, cw_t'{ub: 1'b1, default: '0});
        add_row(11'b10110100000, 11'h7F8, cw_t'{cbz: 1'b1, default: '0});
        add_row(11'b01010100000, 11'h7F8, cw_t'{bcond: 1'b1, default: '0});

        // reset, then the five-instruction pipeline fill
        step(0, 0, 32'h0, 0, 4'h0);
        step(0, 1, mk(3, 4'h0), 0, 4'h0);
        step(1, 1, mk(0, 4'h0), 0, 4'h0);
        step(1, 1, mk(1, 4'h0), 0, 4'h0);
        step(1, 1, mk(2, 4'h0), 0, 4'h0);
        step(1, 1, mk(6, 4'h0), 0, 4'h0);
        step(1, 1, mk(7, 4'h0), 0, 4'h0);
        repeat (4) step(1, 0, 32'h0, 0, 4'h0);
        // SUBS (N=1) then B.LT, presented twice for the stalling variant
        step(1, 1, mk(4, 4'h0), 0, 4'h0);
        step(1, 1, mk(10, 4'hB), 0, 4'b1000);
        step(1, 1, mk(10, 4'hB), 0, 4'b0000);
        step(1, 0, 32'h0, 0, 4'h0);
        // flags_q = 0100, then EQ/NE/GT/LE
        step(1, 1, mk(3, 4'h0), 0, 4'h0);
        step(1, 0, 32'h0, 0, 4'b0100);
        step(1, 0, 32'h0, 0, 4'h0);
        step(1, 1, mk(10, 4'h0), 0, 4'h0);
        step(1, 1, mk(10, 4'h1), 0, 4'h0);
        step(1, 1, mk(10, 4'hC), 0, 4'h0);
        step(1, 1, mk(10, 4'hD), 0, 4'h0);
        // CBZ taken in EX squashes a true B.EQ in ID
        step(1, 1, mk(9, 4'h0), 0, 4'h0);
        step(1, 1, mk(10, 4'h0), 0, 4'b0100);
        step(1, 0, 32'h0, 0, 4'h0);
        // three stalled cycles with ADDS in EX, then resume
        step(1, 1, mk(3, 4'h0), 0, 4'h0);
        repeat (3) step(1, 1, mk(10, 4'hB), 1, 4'b0011);
        step(1, 0, 32'h0, 0, 4'b0011);
        step(1, 0, 32'h0, 0, 4'h0);
        // reset with ADDS in EX
        step(1, 1, mk(3, 4'h0), 0, 4'h0);
        step(0, 1, mk(0, 4'h0), 0, 4'b1111);
        step(1, 0, 32'h0, 0, 4'h0);
        step(1, 0, 32'h0, 0, 4'h0);

        for (int n = 0; n < 800; n++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : conds[$urandom_range(0, 5)];
            step($urandom_range(0, 60) != 0, $urandom_range(0, 4) != 0,
                 mk($urandom_range(0, 12), c), $urandom_range(0, 7) == 0, 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
